// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder.
// Optional build macro used by this slice: UART_TX_FIFO_LEVEL_EN.
package uart_pkg;

    localparam int UART_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered occupancy count.
// The count port exists only when UART_TX_FIFO_LEVEL_EN is defined.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               wr_en,
    input  logic [UART_DW-1:0] wr_data,
    input  logic               rd_en,
    output logic [UART_DW-1:0] rd_data,
    output logic               full,
    output logic               empty
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [ADDR_W:0]    count
`endif
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [UART_DW-1:0] mem_q [2**ADDR_W];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               wr_ok;
    logic               rd_ok;

    // Both flags come from the count registered at cycle start, so a pop in
    // the same cycle never frees a slot for a write.
    assign full    = (count_q == DEPTH);
    assign empty   = (count_q == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    assign count = count_q;
`endif

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// FIFO-buffered feeder that hands bytes one at a time to the UART transmit stage.
// Define UART_TX_FIFO_LEVEL_EN to export Fifo_Level and a sticky Ovf_Flag.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Wr_En,
    input  logic [UART_DW-1:0] Wr_Data,
    output logic               Full,
    output logic               Empty,
    output logic               Tx_En_Sig,
    output logic [UART_DW-1:0] Tx_Data,
    input  logic               Tx_Done_Sig,
    output logic               Busy
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [ADDR_W:0]    Fifo_Level,
    output logic               Ovf_Flag
`endif
);

    tx_state_e          state_q, state_d;
    logic [UART_DW-1:0] data_q, data_d;
    logic               en_q, en_d;
    logic               pop;
    logic [UART_DW-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;

    uart_sync_fifo #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (Wr_En),
        .wr_data (Wr_Data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .count   (Fifo_Level)
`endif
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    data_d  = head;
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (Tx_Done_Sig) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // One cycle with enable still high lets the transmit stage
                // clear its done flag before the next byte is presented.
                if (!fifo_empty) begin
                    data_d  = head;
                    pop     = 1'b1;
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        en_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            data_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    logic ovf_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (Wr_En && fifo_full) begin
            ovf_q <= 1'b1;
        end
    end

    assign Ovf_Flag = ovf_q;
`endif

    assign Full      = fifo_full;
    assign Empty     = fifo_empty;
    assign Tx_En_Sig = en_q;
    assign Tx_Data   = data_q;
    assign Busy      = (state_q != IDLE);

endmodule
